// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared state type, requester indices and address-width helper for the write arbiter
package regarb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } regarb_state_t;

  localparam int REQ_WB  = 0;
  localparam int REQ_AUX = 1;

  function automatic int regarb_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - plain D flip-flop vector with synchronous active-high clear
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/regarb_out_stage.sv
// rtl/regarb_out_stage.sv - registered write port: enable follows the grant, address/data load only on a grant
module regarb_out_stage #(
  parameter int width = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [AW-1:0]    i_addr,
  input  logic [width-1:0] i_data,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [width-1:0] o_wr_data
);

  logic [AW-1:0]    w_addr_d;
  logic [width-1:0] w_data_d;

  assign w_addr_d = i_load ? i_addr : o_wr_addr;
  assign w_data_d = i_load ? i_data : o_wr_data;

  dff #(.W(1))     u_en   (.clk(clk), .rst(rst), .i_d(i_load),   .o_q(o_wr_en));
  dff #(.W(AW))    u_addr (.clk(clk), .rst(rst), .i_d(w_addr_d), .o_q(o_wr_addr));
  dff #(.W(width)) u_data (.clk(clk), .rst(rst), .i_d(w_data_d), .o_q(o_wr_data));

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin two-requester register-file write arbiter with requester-1 burst lock
// Optional forwarding ports are added when REGARB_FWD_EN is defined.
module regfile_wr_arbiter
  import regarb_pkg::*;
#(
  parameter  int width = 16,
  parameter  int nregs = 8,
  localparam int AW    = regarb_aw(nregs)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0Valid,
  input  logic [AW-1:0]    req0Addr,
  input  logic [width-1:0] req0Data,
  output logic             req0Ready,
  input  logic             req1Valid,
  input  logic             req1Lock,
  input  logic [AW-1:0]    req1Addr,
  input  logic [width-1:0] req1Data,
  output logic             req1Ready,
  output logic             wrEn,
  output logic [AW-1:0]    wrAddr,
  output logic [width-1:0] wrData,
`ifdef REGARB_FWD_EN
  input  logic [AW-1:0]    fwdAddr,
  output logic             fwdHit,
  output logic [width-1:0] fwdData,
`endif
  output logic             err
);

  regarb_state_t r_state, w_state_nxt;
  logic          r_prio, w_prio_nxt;
  logic          w_gnt0, w_gnt1, w_tie, w_err;

  assign w_tie = req0Valid & req1Valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_prio  <= 1'(REQ_WB);
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Leaving LOCK1 always hands the next tie to the writeback requester.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      ARB: begin
        if (w_tie)              w_prio_nxt  = w_gnt0 ? 1'(REQ_AUX) : 1'(REQ_WB);
        if (w_gnt1 && req1Lock) w_state_nxt = LOCK1;
      end
      LOCK1: begin
        if (!req1Valid || !req1Lock) begin
          w_state_nxt = ARB;
          w_prio_nxt  = 1'(REQ_WB);
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      case (r_state)
        ARB: begin
          w_gnt0 = req0Valid && (!req1Valid || r_prio == 1'(REQ_WB));
          w_gnt1 = req1Valid && (!req0Valid || r_prio == 1'(REQ_AUX));
        end
        LOCK1:   w_gnt1 = req1Valid;
        default: ;
      endcase
    end
  end

  assign req0Ready = w_gnt0;
  assign req1Ready = w_gnt1;

  regarb_out_stage #(.width(width), .AW(AW)) u_out (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_gnt0 | w_gnt1),
    .i_addr   (w_gnt1 ? req1Addr : req0Addr),
    .i_data   (w_gnt1 ? req1Data : req0Data),
    .o_wr_en  (wrEn),
    .o_wr_addr(wrAddr),
    .o_wr_data(wrData)
  );

  // X on address/data only matters while that requester is presenting a write.
  always_comb begin
    w_err = 1'b0;
    if (req0Valid === 1'bx || req1Valid === 1'bx || req1Lock === 1'bx) w_err = 1'b1;
    if (req0Valid === 1'b1 && (^{req0Addr, req0Data}) === 1'bx)         w_err = 1'b1;
    if (req1Valid === 1'b1 && (^{req1Addr, req1Data}) === 1'bx)         w_err = 1'b1;
  end

  assign err = w_err;

`ifdef REGARB_FWD_EN
  assign fwdHit  = wrEn & (wrAddr == fwdAddr);
  assign fwdData = wrData;
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Two-requester arbiter for the single register-file write port. It sits between the writeback stage (requester 0) and the secondary write source (requester 1, e.g. load-return/restore path) and the register file built from `reg1` instances. Each cycle it grants at most one requester by round-robin, with an optional burst lock for requester 1. It registers the winning address and data onto the register file's write enable and data inputs.

## Interface
- `width`, 16, data width of one register
- `nregs`, 8, number of registers; address width `AW = $clog2(nregs)`

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req0Valid`  in  1  requester 0 has a write
- `req0Addr`  in  AW  destination register
- `req0Data`  in  width  write data
- `req0Ready`  out  1  requester 0 granted this cycle
- `req1Valid`  in  1  requester 1 has a write
- `req1Lock`  in  1  requester 1 requests back-to-back ownership
- `req1Addr`  in  AW  destination register
- `req1Data`  in  width  write data
- `req1Ready`  out  1  requester 1 granted this cycle
- `wrEn`  out  1  register-file write enable; one-hot decode is the register file's job
- `wrAddr`  out  AW  register-file write address
- `wrData`  out  width  register-file write data
- `err`  out  1  X detected on any valid, lock, or the address/data of a valid requester

## Operation
- The handshake completes when `reqNValid & reqNReady` at a rising edge. Ready is combinational from valid, state and pointer. A requester must hold addr and data stable while valid and not ready.
- The round-robin pointer `prio` is initially 0 and selects the favoured requester when both are valid.
- FSM states:
  - ARB (reset state):
    - If only one requester is valid, grant it.
    - If both are valid, grant `prio` and set `prio` to the other requester.
    - A grant to requester 1 with `req1Lock=1` moves to LOCK1.
  - LOCK1:
    - Requester 1 is the only candidate. `req0Ready=0` even if requester 0 is valid.
    - Each `req1Valid` grants requester 1. `prio` is unchanged.
    - Return to ARB when a grant occurs with `req1Lock=0`, or when `req1Valid=0`.
    - After exit, `prio=0`, so requester 0 wins the next tie.
- Output stage:
  - On a grant, `wrEn`, `wrAddr` and `wrData` load the winner's values.
  - With no grant, `wrEn` loads 0 and `wrAddr`/`wrData` hold their previous values.
- Both requesters targeting the same register in one cycle: only the winner writes. The loser writes in a later cycle, and its value overwrites the winner's.
- `err` is combinational. It uses `===` X checks, matching `reg1` error semantics, and has no effect on arbitration.

## Timing
- Grant to register-file write: the register file sees `wrEn=1` in the cycle after the grant. The register content updates at the following edge, 2 edges after the request edge.
- Throughput: 1 write per cycle sustained. Under a two-way tie, writes alternate 0,1,0,1.
- Reset values: `wrEn=0`, `wrAddr=0`, `wrData=0`, state ARB, `prio=0`, both readies 0 while `rst=1`.
- Reset asserted mid-burst: LOCK1 is abandoned at that edge, and no write is issued in the following cycle.
- `req1Lock` is ignored when `req1Valid=0`.

## Configuration
- `REGARB_FWD_EN`: adds the ports `fwdAddr` (in, AW), `fwdHit` (out, 1) and `fwdData` (out, width).
  - `fwdHit = wrEn & (wrAddr == fwdAddr)`.
  - `fwdData = wrData`.
  - This covers a decode-stage read in the same cycle the register file is written.
- Undefined: those ports do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `regarb_pkg`:
  - state enum `{ARB, LOCK1}`
  - `AW` derivation
  - requester index constants `REQ_WB=0`, `REQ_AUX=1`
- The output stage is one `reg1`-style registered sub-module, `regarb_out_stage`, holding `wrEn`, `wrAddr` and `wrData` with load-on-grant. It is built from `dff` instances, like the rest of the codebase.
- The arbitration FSM and `prio` live in the top module.

## Test plan
- Reset, then idle: `wrEn=0`, `wrAddr=0`, `wrData=0` and both readies 0 for 3 cycles.
- `req0Valid` with addr=3, data=`16'hBEEF`: `req0Ready=1` the same cycle. Next cycle `wrEn=1`, `wrAddr=3`, `wrData=16'hBEEF`.
- Both requesters valid for 4 cycles, with data `16'h0001` and `16'h0002` respectively: grants go 0,1,0,1 and the `wrData` sequence is 1,2,1,2.
- Requester 1 burst with lock for 3 writes (addr 1,2,3) while requester 0 is continuously valid:
  - `req0Ready=0` for 3 cycles.
  - On the cycle after the third grant, requester 0 is granted.
- Same register, both valid, addr=5, data `16'hAAAA` (requester 0) and `16'h5555` (requester 1): after both writes the register holds `16'h5555`.
- With `REGARB_FWD_EN` defined:
  - `fwdAddr=3` during a `wrEn` cycle to reg 3 gives `fwdHit=1` and `fwdData` equal to the written value.
  - `fwdAddr=4` gives `fwdHit=0`.
